// File: rtl/press_pkg.sv
// Shared types for the press classifier: FSM states and event codes.
package press_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPressed,
        StGap,
        StPressed2
    } press_state_t;

    typedef enum logic [1:0] {
        EvtNone   = 2'b00,
        EvtShort  = 2'b01,
        EvtLong   = 2'b10,
        EvtDouble = 2'b11
    } press_evt_t;

endpackage

// File: rtl/press_evt_hold.sv
// One-entry valid/ready holding register for classified events, with sticky overrun.
module press_evt_hold
    import press_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       emit,
    input  press_evt_t emit_code,
    input  logic       evt_ready,
    input  logic       ovr_clr,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       overrun
);

    logic       valid_q, valid_d;
    press_evt_t code_q, code_d;
    logic       overrun_q, overrun_d;
    logic       freed;
    logic       drop;

    assign freed = valid_q && evt_ready;
    // A slot freed by this cycle's handshake can take a new event immediately.
    assign drop  = emit && valid_q && !freed;

    always_comb begin
        valid_d   = valid_q;
        code_d    = code_q;
        overrun_d = overrun_q;
        if (freed) begin
            valid_d = 1'b0;
            code_d  = EvtNone;
        end
        if (emit && !drop) begin
            valid_d = 1'b1;
            code_d  = emit_code;
        end
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            valid_q   <= 1'b0;
            code_q    <= EvtNone;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            code_q    <= code_d;
            overrun_q <= overrun_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_code  = code_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/press_classifier.sv
// Times press and release edges and classifies each gesture as SHORT, LONG or DOUBLE.
module press_classifier
    import press_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned LONG_TICKS = 1000,
    parameter int unsigned DBL_GAP    = 200
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       pos_edge,
    input  logic       neg_edge,
    input  logic       evt_ready,
    input  logic       ovr_clr,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    output logic       overrun,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LongTh = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] GapTh  = CNT_W'(DBL_GAP);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    press_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_sat;
    logic             pe, ne;
    logic             emit;
    press_evt_t       emit_code;

    // Simultaneous press and release is a glitch: treat both as absent.
    assign pe      = pos_edge && !neg_edge;
    assign ne      = neg_edge && !pos_edge;
    assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_code = EvtNone;
        unique case (state_q)
            StIdle: begin
                if (pe) begin
                    state_d = StPressed;
                    cnt_d   = CntOne;
                end
            end
            StPressed: begin
                cnt_d = cnt_sat;
                if (ne) begin
                    if (cnt_q >= LongTh) begin
                        emit      = 1'b1;
                        emit_code = EvtLong;
                        state_d   = StIdle;
                        cnt_d     = '0;
                    end else begin
                        state_d = StGap;
                        cnt_d   = CntOne;
                    end
                end
            end
            StGap: begin
                if (pe) begin
                    state_d = StPressed2;
                end else if (cnt_q == GapTh) begin
                    emit      = 1'b1;
                    emit_code = EvtShort;
                    state_d   = StIdle;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            StPressed2: begin
                cnt_d = cnt_sat;
                if (ne) begin
                    emit      = 1'b1;
                    emit_code = EvtDouble;
                    state_d   = StIdle;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != StIdle);

    press_evt_hold u_hold (
        .clk       (clk),
        .n_rst     (n_rst),
        .emit      (emit),
        .emit_code (emit_code),
        .evt_ready (evt_ready),
        .ovr_clr   (ovr_clr),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .overrun   (overrun)
    );

endmodule

// File: doc/press_classifier.md
# press_classifier

Single-channel press classifier sitting directly downstream of the edge detector. It consumes one lane's `pos_edge`/`neg_edge` pulses, times each press and the gap after it, and classifies the gesture as SHORT, LONG or DOUBLE. Each classified event is delivered through a one-entry valid/ready holding register to the consuming logic (interrupt or CSR block). Dropped events are flagged by a sticky overrun bit.

## Interface
- `CNT_W`, 16: width of the hold/gap counter.
- `LONG_TICKS`, 1000: minimum hold length in clocks for a LONG; legal range 1 .. 2^CNT_W−2.
- `DBL_GAP`, 200: maximum release-to-press gap in clocks for a DOUBLE; legal range 1 .. 2^CNT_W−2.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, all logic on its rising edge.
- `n_rst`  in  1  synchronous active-low reset.
- `pos_edge`  in  1  one-cycle press pulse from the edge detector.
- `neg_edge`  in  1  one-cycle release pulse from the edge detector.
- `evt_ready`  in  1  consumer accepts `evt_code` this cycle.
- `ovr_clr`  in  1  clears `overrun`.
- `evt_valid`  out  1  holding register occupied.
- `evt_code`  out  2  01 SHORT, 10 LONG, 11 DOUBLE; 00 when not valid.
- `overrun`  out  1  sticky; set when an event was dropped.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Counter `cnt` (CNT_W bits) saturates at all-ones and never wraps.
- Hold length H = cycle index of `neg_edge` minus cycle index of `pos_edge`.
- Gap G = cycle index of the next `pos_edge` minus cycle index of `neg_edge`.
- `pos_edge` and `neg_edge` high in the same cycle is treated as a glitch: both are ignored and the state and `cnt` advance as if both were low.
- IDLE:
  - `pos_edge` → PRESSED, `cnt`←1.
  - `neg_edge` ignored.
- PRESSED: `cnt`←sat(`cnt`+1) each cycle.
  - On `neg_edge`, if `cnt`≥LONG_TICKS: emit LONG, → IDLE.
  - Otherwise → GAP, `cnt`←1.
- GAP:
  - `pos_edge` → PRESSED2. This covers G≤DBL_GAP.
  - Otherwise, when `cnt`==DBL_GAP: emit SHORT, → IDLE.
  - Otherwise `cnt`←`cnt`+1.
- PRESSED2: `neg_edge` → emit DOUBLE, → IDLE. The second press duration is not classified.
- A `pos_edge` arriving at G=DBL_GAP+1 finds the FSM in IDLE and starts a new press.
- Holding register, evaluated in order:
  1. `evt_valid`&&`evt_ready` frees the slot.
  2. An emit that finds the slot free (including a slot freed in step 1 this cycle) loads it.
  3. An emit that finds the slot occupied and not freed is dropped, `overrun`←1, and `evt_code` is unchanged.
- `ovr_clr` clears `overrun`. A drop in the same cycle wins, so `overrun` stays 1.

## Timing
- Reset values: state IDLE, `cnt`=0, `evt_valid`=0, `evt_code`=00, `overrun`=0, `busy`=0.
- Reset mid-gesture discards the gesture with no emit. A later `neg_edge` from that gesture is ignored in IDLE.
- Emit latency: `evt_valid` rises in the cycle after the triggering `neg_edge`, or after the GAP timeout cycle.
- `evt_valid`/`evt_code` hold stable until the handshake completes.
- `busy` is registered state decode. It is 1 in the cycle after `pos_edge` is accepted in IDLE.
- Throughput: one event per cycle when `evt_ready` is held high.

## Structure
- Package `press_pkg`:
  - `press_state_t` enum: IDLE, PRESSED, GAP, PRESSED2.
  - `press_evt_t` 2-bit enum: NONE, SHORT, LONG, DOUBLE.
- Sub-module `press_evt_hold`: one-entry valid/ready holding register with overrun and clear logic.
- Top-level `press_classifier` contains the FSM and counter.

## Test plan
All scenarios use LONG_TICKS=8 and DBL_GAP=4.
- pos@10, neg@13, no further edges → `evt_valid`=1 @18 with `evt_code`=01; `busy`=0 @18.
- pos@10, neg@18 (H=8) → LONG (10) @19. Repeat with neg@17 (H=7) → SHORT @22.
- pos@10, neg@12, pos@16 (G=4), neg@20 → DOUBLE (11) @21. Repeat with pos@17 (G=5) → SHORT @17, then a new press starts.
- `evt_ready`=0, two SHORT gestures back-to-back → first code held, `overrun`=1 after the second emit. `ovr_clr` pulse → `overrun`=0. `evt_ready` pulse → `evt_valid`=0.
- `evt_ready`=1 in the exact cycle a second event emits → second event loaded, `overrun` stays 0.
- `n_rst` low @14 during PRESSED (pos@10) → all outputs at reset values @15; neg@16 produces no event. Same-cycle pos&neg in IDLE → no state change.
